// File: rtl/if_of_skid_reg.sv
// IF/OF pipeline register with a 2-entry skid buffer, flush-to-bubble and a
// saturating counter of cycles where OF was ready but had nothing to take.
// Every output comes straight from a flop, so downstream sees no
// combinational path from any input.
module if_of_skid_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h68000000,
  parameter int                 CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INSTR_W-1:0]        instruction_i,
  input  logic [PC_W-1:0]           pc_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [INSTR_W+PC_W-1:0]   of,
  input  logic                      flush,
  input  logic                      clr_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  localparam int DW = INSTR_W + PC_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // A bubble carries the nop encoding and a zero PC.
  localparam logic [DW-1:0] BUBBLE = {NOP_INSTR, {PC_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DW-1:0]     main_q, main_d;
  logic [DW-1:0]     skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DW-1:0]     in_data_s;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_data_s  = {instruction_i, pc_i};
  // in_ready_q is a flop, so acceptance never depends on out_ready this cycle.
  assign in_fire_s  = in_valid & in_ready_q & ~flush;
  assign out_fire_s = out_valid_q & out_ready;

  // Next-state, data steering and registered handshake flags.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d = ST_FULL;
            main_d  = in_data_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (in_fire_s && out_fire_s) begin
            main_d = in_data_s;
          end else if (in_fire_s) begin
            // Downstream stalled: park the newer word behind the held one.
            state_d = ST_SKID;
            skid_d  = in_data_s;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          if (out_fire_s) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Whenever nothing real is held, the output reads as a bubble.
    if (state_d == ST_EMPTY) begin
      main_d = BUBBLE;
    end else begin
      main_d = main_d;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  // Starved-cycle counter: clear beats increment, holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (out_ready && !out_valid_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and data registers; reset drops all held data immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= {DW{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign of         = main_q;
  assign out_valid  = out_valid_q;
  assign in_ready   = in_ready_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_if_of_skid_reg.sv
// Directed, table-driven bench for if_of_skid_reg (counter width 4 so that
// saturation is reachable quickly).
module tb_if_of_skid_reg;

  localparam int CW = 4;
  localparam logic [63:0] NOP64 = 64'h68000000_00000000;
  localparam logic [63:0] A5 = 64'hA5A5A5A5_00000004;
  localparam logic [63:0] DB = 64'hDEADBEEF_00000008;
  localparam logic [63:0] C1 = 64'h12345678_0000000C;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instruction_i;
  logic [31:0]   pc_i;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [63:0]   of;
  logic          flush;
  logic          clr_cnt;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  if_of_skid_reg #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instruction_i(instruction_i), .pc_i(pc_i),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .out_valid(out_valid), .of(of), .flush(flush), .clr_cnt(clr_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] din;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_of;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [63:0] din, input logic ordy,
                              input logic fl, input logic clr, input logic e_ov,
                              input logic e_ir, input logic [63:0] e_of, input logic [3:0] e_cnt);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl; v.clr = clr;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_of = e_of; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [63:0] din, input logic ordy,
                       input logic fl, input logic clr);
    in_valid = iv; instruction_i = din[63:32]; pc_i = din[31:0];
    out_ready = ordy; flush = fl; clr_cnt = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_cnt;
    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    //          iv    din   ordy  fl    clr   ov    ir    of     cnt
    vt[0]  = mk(1'b0, NOP64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NOP64, 4'd1);
    vt[1]  = mk(1'b0, NOP64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NOP64, 4'd2);
    vt[2]  = mk(1'b1, A5,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, A5,    4'd3);
    vt[3]  = mk(1'b1, DB,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, DB,    4'd3);
    vt[4]  = mk(1'b0, NOP64, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, NOP64, 4'd0);
    vt[5]  = mk(1'b1, A5,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A5,    4'd0);
    vt[6]  = mk(1'b1, DB,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, A5,    4'd0);
    vt[7]  = mk(1'b1, C1,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, A5,    4'd0);
    vt[8]  = mk(1'b1, C1,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, DB,    4'd0);
    vt[9]  = mk(1'b1, C1,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, C1,    4'd0);
    vt[10] = mk(1'b0, NOP64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NOP64, 4'd0);
    vt[11] = mk(1'b0, NOP64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NOP64, 4'd1);
    vt[12] = mk(1'b1, A5,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A5,    4'd1);
    vt[13] = mk(1'b1, DB,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, A5,    4'd1);
    vt[14] = mk(1'b1, C1,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, NOP64, 4'd1);
    vt[15] = mk(1'b0, NOP64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP64, 4'd1);
    vt[16] = mk(1'b1, A5,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A5,    4'd1);
    vt[17] = mk(1'b0, NOP64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, NOP64, 4'd1);
    vt[18] = mk(1'b1, DB,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, NOP64, 4'd1);
    vt[19] = mk(1'b1, A5,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A5,    4'd1);
    vt[20] = mk(1'b0, NOP64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A5,    4'd1);
    vt[21] = mk(1'b0, NOP64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NOP64, 4'd1);

    // Reset for two cycles, then release away from the clock edge.
    tick;
    tick;
    reset = 1'b0;
    chk("rst_of", of, NOP64);
    chk("rst_out_valid", {63'd0, out_valid}, {63'd0, 1'b0});
    chk("rst_in_ready", {63'd0, in_ready}, {63'd0, 1'b1});
    chk("rst_cnt", {60'd0, bubble_cnt}, 64'd0);

    // Table: apply, clock, compare the registered outputs.
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].iv, vt[i].din, vt[i].ordy, vt[i].fl, vt[i].clr);
      tick;
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].e_ov});
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vt[i].e_ir});
      chk($sformatf("v%0d_of", i), of, vt[i].e_of);
      chk($sformatf("v%0d_cnt", i), {60'd0, bubble_cnt}, {60'd0, vt[i].e_cnt});
    end

    // Asynchronous reset mid-cycle while in SKID.
    drive(1'b1, A5, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, DB, 1'b0, 1'b0, 1'b0);
    tick;
    chk("skid_in_ready", {63'd0, in_ready}, {63'd0, 1'b0});
    drive(1'b0, NOP64, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, {63'd0, 1'b0});
    chk("arst_of", of, NOP64);
    chk("arst_in_ready", {63'd0, in_ready}, {63'd0, 1'b1});
    chk("arst_cnt", {60'd0, bubble_cnt}, 64'd0);
    tick;
    reset = 1'b0;
    // Held data must be gone: with OF ready, the output stays a bubble.
    drive(1'b0, NOP64, 1'b1, 1'b0, 1'b0);
    tick;
    chk("post_rst_of", of, NOP64);
    chk("post_rst_out_valid", {63'd0, out_valid}, {63'd0, 1'b0});

    // Saturation: continue starving OF for 20 more cycles.
    exp_cnt = 4'd1;
    for (int k = 0; k < 20; k++) begin
      tick;
      exp_cnt = (exp_cnt == 4'd15) ? 4'd15 : exp_cnt + 4'd1;
      chk($sformatf("sat%0d_cnt", k), {60'd0, bubble_cnt}, {60'd0, exp_cnt});
    end
    chk("sat_final", {60'd0, bubble_cnt}, 64'd15);

    // Clear wins over increment, then counting resumes.
    drive(1'b0, NOP64, 1'b1, 1'b0, 1'b1);
    tick;
    chk("clr_cnt", {60'd0, bubble_cnt}, 64'd0);
    drive(1'b0, NOP64, 1'b1, 1'b0, 1'b0);
    tick;
    chk("clr_then_inc", {60'd0, bubble_cnt}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
